// File: rtl/cla_serial_add_ctrl_pkg.sv
// Shared constants and state encoding for the nibble-serial CLA add/sub sequencer.
package cla_serial_add_ctrl_pkg;

  // Width of the reused carry-lookahead slice.
  localparam int unsigned NIBW = 4;

  // Sequencer states; encodings are fixed so external debug taps stay stable.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla_slice4
  import cla_serial_add_ctrl_pkg::*;
(
  input  logic [NIBW-1:0] a,
  input  logic [NIBW-1:0] b,
  input  logic            cin,
  output logic [NIBW-1:0] s,
  output logic            cout
);

  logic [NIBW-1:0] g;
  logic [NIBW-1:0] p;
  logic [NIBW:0]   c;

  // Carries are flattened generate/propagate sums, so no carry ripples through the slice.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[NIBW-1:0];
    cout = c[NIBW];
  end

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit CLA slice reused LSB nibble first,
// with valid/ready handshakes on both the operand and result sides.
module cla_serial_add_ctrl
  import cla_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NSTEP = WIDTH / NIBW;
  localparam int unsigned IW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  state_e                     state_q;
  logic [IW-1:0]              idx_q;
  logic [NSTEP-1:0][NIBW-1:0] a_q;
  logic [NSTEP-1:0][NIBW-1:0] b_q;
  logic [NSTEP-1:0][NIBW-1:0] sum_q;
  logic                       carry_q;
  logic                       c_out_q;
  logic                       ovf_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic                       busy_q;

  logic [NIBW-1:0]            slice_s_c;
  logic                       slice_co_c;
  logic                       last_c;

  // The single shared slice always works on the nibble selected by idx.
  cla_slice4 u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .s    (slice_s_c),
    .cout (slice_co_c)
  );

  assign last_c = (idx_q == IW'(NSTEP - 1));

  // Sequencer state, operand/result registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            // Subtraction is a + ~b + 1, so invert b and force the carry-in here.
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry_q    <= sub | c_in;
            idx_q      <= '0;
            sum_q      <= '0;
            state_q    <= ST_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          sum_q[idx_q] <= slice_s_c;
          carry_q      <= slice_co_c;
          idx_q        <= idx_q + IW'(1);
          if (last_c) begin
            c_out_q     <= slice_co_c;
            ovf_q       <= (a_q[NSTEP-1][NIBW-1] == b_q[NSTEP-1][NIBW-1]) &&
                           (slice_s_c[NIBW-1] != a_q[NSTEP-1][NIBW-1]);
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule
